nibbler_button_port: RTL

//   Input-side peripheral for the Nibbler microprocessor: the circuit that produces what the core reads on its 4-bit input port.

---
 rtl/nibbler_pkg.sv | 10 +
 rtl/nibbler_debounce_bit.sv | 55 +++++
 rtl/nibbler_button_port.sv | 73 +++++++
 3 files changed

// File: rtl/nibbler_pkg.sv
// Shared constants for the Nibbler input-port peripheral.
// Gives the nibble width, the read_sel encodings and the default debounce length.
package nibbler_pkg;

    localparam int   NIBBLE_W            = 4;
    localparam logic READ_LEVELS         = 1'b0;
    localparam logic READ_EVENTS         = 1'b1;
    localparam int   DEBOUNCE_CYCLES_DEF = 16;

endpackage : nibbler_pkg

// File: rtl/nibbler_debounce_bit.sv
// One pushbutton: 2-FF synchroniser, hold-time debounce counter, debounced level
// and a single-cycle pulse on the debounced 0->1 transition.
module nibbler_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // NOTE: non-blocking assignments so sync2_q takes the old sync1_q and the chain really is two flops deep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_o   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                rise_o   = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable_o = stable_q;

endmodule : nibbler_debounce_bit

// File: rtl/nibbler_button_port.sv
// Nibbler input port: debounced pushbutton levels plus sticky press flags,
// returned as one registered nibble when the core executes an IN instruction.
module nibbler_button_port
    import nibbler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int WIDTH           = NIBBLE_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pushbuttons,
    input  logic             rd_strobe,
    input  logic             read_sel,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [WIDTH-1:0] btn_stable,
    output logic [WIDTH-1:0] btn_event
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] event_q;
    logic [WIDTH-1:0] event_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nibbler_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i   (clock),
            .rst_ni  (reset),
            .raw_i   (pushbuttons[i]),
            .stable_o(stable_w[i]),
            .rise_o  (rise_w[i])
        );
    end

    // A press landing on the same edge as the clearing read survives: the new set is OR-ed in after the clear.
    always_comb begin
        read_data = (read_sel == READ_EVENTS) ? event_q : stable_w;
        event_d   = event_q | rise_w;
        data_d    = data_q;
        valid_d   = rd_strobe;
        if (rd_strobe) begin
            data_d = read_data;
            if (read_sel == READ_EVENTS) begin
                event_d = (event_q & ~read_data) | rise_w;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            event_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            event_q <= event_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign btn_stable = stable_w;
    assign btn_event  = event_q;

endmodule : nibbler_button_port
